// File: rtl/data_mem_responder_if.sv
// Data-memory port between the core's memory stage (master) and the
// memory responder (slave): a request channel and a response channel,
// each with its own valid/ready handshake.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a
// programmable number of cycles, accesses a word-organised SRAM with
// byte-lane writes and returns the raw aligned word (or an error).
module data_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1
) (
   input logic                clk,
   input logic                reset_n,
   data_mem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]  state;
   logic [3:0]  wait_cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [1:0]  lat_size;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic [31:0] mem [DEPTH_WORDS];

   logic [32:0]      offset;
   logic             in_range;
   logic             misaligned;
   logic             req_err;
   logic [IDX_W-1:0] word_idx;
   logic [3:0]       lane_en;
   logic [31:0]      lane_data;
   logic             mem_we;
   logic             accept;

   assign bus.req_ready  = (state == S_IDLE);
   assign bus.resp_valid = (state == S_RESP);
   assign bus.resp_rdata = resp_rdata;
   assign bus.resp_err   = resp_err;

   assign accept = bus.req_valid && (state == S_IDLE);

   // Decode the latched request: range, alignment, word index and lane enables.
   always_comb begin
      // 33-bit difference keeps both range limits free of wrap-around
      offset     = {1'b0, lat_addr} - {1'b0, BASE_ADDR};
      in_range   = !offset[32] && (offset < 33'(4 * DEPTH_WORDS));
      misaligned = 1'b0;
      lane_en    = 4'b0000;
      lane_data  = lat_wdata;
      case (lat_size)
         SZ_BYTE: begin
            lane_en   = 4'b0001 << lat_addr[1:0];
            lane_data = {4{lat_wdata[7:0]}};
         end
         SZ_HALF: begin
            misaligned = lat_addr[0];
            lane_en    = lat_addr[1] ? 4'b1100 : 4'b0011;
            lane_data  = {2{lat_wdata[15:0]}};
         end
         SZ_WORD: begin
            misaligned = (lat_addr[1:0] != 2'b00);
            lane_en    = 4'b1111;
         end
         default: misaligned = 1'b1;
      endcase
      req_err  = misaligned || !in_range;
      word_idx = offset[IDX_W+1:2];
      mem_we   = (state == S_ACCESS) && lat_we && !req_err;
   end

   // Capture the request at acceptance; held until the next acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we    <= bus.req_we;
         lat_addr  <= bus.req_addr;
         lat_wdata <= bus.req_wdata;
         lat_size  <= bus.req_size;
      end
   end

   // SRAM write port: only enabled lanes of a legal store change.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

   // Control FSM, wait counter and registered response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         wait_cnt   <= 4'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  wait_cnt <= 4'd0;
                  state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               // counter steps 1..WAIT_CYCLES; leave once it has reached the end
               if (wait_cnt == 4'(WAIT_CYCLES)) state <= S_ACCESS;
               else                             wait_cnt <= wait_cnt + 4'd1;
            end
            S_ACCESS: begin
               resp_err   <= req_err;
               resp_rdata <= (req_err || lat_we) ? 32'd0 : mem[word_idx];
               state      <= S_RESP;
            end
            default: begin
               if (bus.resp_ready) state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a response scoreboard.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   data_mem_responder_if bus ();

   data_mem_responder #(
      .BASE_ADDR  (32'h8000_0000),
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES(1)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   resp_t sb_q[$];
   int total  = 0;
   int passed = 0;
   int failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request from a negedge, wait for its response; lat = -1 on timeout.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic [31:0] exp_rdata,
                        input logic exp_err, output int lat);
      int n;
      resp_t e;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb_q.push_back(e);
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_size  = size;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.resp_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic compare_resp(input string tag);
      resp_t e;
      e = sb_q.pop_front();
      check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
      check({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
   endtask

   task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      issue(we, addr, wdata, size, exp_rdata, exp_err, lat);
      check({tag, "_latency"}, 32'(lat), 32'd3);
      compare_resp(tag);
      @(negedge clk);
      check({tag, "_one_cycle"}, 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      int lat;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.req_size   = 2'b10;
      bus.resp_ready = 1'b1;

      // Reset values
      #12;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'd0);
      check("rst_err", 32'(bus.resp_err), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: word store then load
      do_req("t1_st", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 32'h0, 1'b0);
      do_req("t1_ld", 1'b0, 32'h8000_0010, 32'h0, 2'b10, 32'hDEAD_BEEF, 1'b0);

      // 2: byte and half lane stores
      do_req("t2_stb", 1'b1, 32'h8000_0013, 32'h0000_00AA, 2'b00, 32'h0, 1'b0);
      do_req("t2_ldb", 1'b0, 32'h8000_0010, 32'h0, 2'b10, 32'hAAAD_BEEF, 1'b0);
      do_req("t2_sth", 1'b1, 32'h8000_0012, 32'h0000_1234, 2'b01, 32'h0, 1'b0);
      do_req("t2_ldh", 1'b0, 32'h8000_0010, 32'h0, 2'b10, 32'h1234_BEEF, 1'b0);

      // 3: misaligned accesses and illegal size
      do_req("t3_ldw_mis", 1'b0, 32'h8000_0002, 32'h0, 2'b10, 32'h0, 1'b1);
      do_req("t3_sth_mis", 1'b1, 32'h8000_0011, 32'hFFFF_FFFF, 2'b01, 32'h0, 1'b1);
      do_req("t3_sz11", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 2'b11, 32'h0, 1'b1);
      do_req("t3_ld", 1'b0, 32'h8000_0010, 32'h0, 2'b10, 32'h1234_BEEF, 1'b0);

      // 4: out-of-range accesses must not alias into word 0
      do_req("t4_st0", 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 2'b10, 32'h0, 1'b0);
      do_req("t4_st_end", 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 2'b10, 32'h0, 1'b1);
      do_req("t4_ld_low", 1'b0, 32'h7FFF_FFFC, 32'h0, 2'b10, 32'h0, 1'b1);
      do_req("t4_ld0", 1'b0, 32'h8000_0000, 32'h0, 2'b10, 32'h0BAD_F00D, 1'b0);
      do_req("t4_ld_last", 1'b1, 32'h8000_0FFC, 32'h7777_7777, 2'b10, 32'h0, 1'b0);
      do_req("t4_ld_last_rd", 1'b0, 32'h8000_0FFC, 32'h0, 2'b10, 32'h7777_7777, 1'b0);

      // 5: response backpressure with ignored request pulses
      bus.resp_ready = 1'b0;
      issue(1'b0, 32'h8000_0010, 32'h0, 2'b10, 32'h1234_BEEF, 1'b0, lat);
      check("t5_latency", 32'(lat), 32'd3);
      compare_resp("t5_first");
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = (i % 2 == 0);
         bus.req_we    = 1'b1;
         bus.req_addr  = 32'h8000_0010;
         bus.req_wdata = 32'hFFFF_FFFF;
         bus.req_size  = 2'b10;
         @(posedge clk);
         @(negedge clk);
         check("t5_hold_valid", 32'(bus.resp_valid), 32'd1);
         check("t5_hold_rdata", bus.resp_rdata, 32'h1234_BEEF);
         check("t5_hold_err", 32'(bus.resp_err), 32'd0);
         check("t5_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t5_released", 32'(bus.resp_valid), 32'd0);
      check("t5_ready_again", 32'(bus.req_ready), 32'd1);
      repeat (4) @(negedge clk);
      check("t5_no_extra_resp", 32'(bus.resp_valid), 32'd0);
      do_req("t5_ld", 1'b0, 32'h8000_0010, 32'h0, 2'b10, 32'h1234_BEEF, 1'b0);

      // 6: reset during WAIT drops the pending store
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h8000_0010;
      bus.req_wdata = 32'h5555_5555;
      bus.req_size  = 2'b10;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("t6_in_wait", 32'(bus.req_ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_ready", 32'(bus.req_ready), 32'd1);
      check("t6_rst_valid", 32'(bus.resp_valid), 32'd0);
      check("t6_rst_rdata", bus.resp_rdata, 32'd0);
      check("t6_rst_err", 32'(bus.resp_err), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_req("t6_ld", 1'b0, 32'h8000_0010, 32'h0, 2'b10, 32'h1234_BEEF, 1'b0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
